instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle control FSM for the non-pipelined RV32I core. It sequences fetch, decode, execute, memory and writeback for each instruction. From the latched opcode it drives the immediate-type select of the sign extender, plus all datapath write enables and muxes. It handshakes with instruction and data memory and applies a per-access timeout.

## Interface
- `MEM_TIMEOUT`, 16: max cycles a memory request may wait for ready before a fault is raised; must be ≥1.
- `CNT_W`, 32: width of the retired-instruction counter.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `opcode` in 7: `instr[6:0]` from the instruction register; valid from DECODE onward.
- `branch_taken` in 1: ALU compare result; sampled in EXECUTE.
- `imem_ready` in 1: instruction memory has returned data.
- `dmem_ready` in 1: data access complete.
- `imem_req` out 1: instruction fetch request.
- `dmem_req` out 1: data access request.
- `dmem_we` out 1: data access is a store.
- `ir_we` out 1: load the instruction register.
- `pc_we` out 1: update the PC.
- `pc_src` out 2: 0 = PC+4, 1 = PC+imm (branch), 2 = rs1+imm (JALR).
- `imm_type` out `Imm_ex_op`: sign-extender select (`I_TYPE`/`S_TYPE`/`B_TYPE`).
- `alu_src_imm` out 1: ALU operand B = immediate.
- `reg_we` out 1: register-file write.
- `wb_sel` out 2: 0 = ALU, 1 = load data, 2 = PC+4.
- `illegal_instr` out 1: one-cycle pulse on an unsupported opcode.
- `mem_fault` out 1: one-cycle pulse on a memory timeout.
- `retired` out `CNT_W`: count of completed instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK.
- Instruction classes decoded in DECODE and registered:
  - R = `0110011`
  - IALU = `0010011`
  - LOAD = `0000011`
  - STORE = `0100011`
  - BRANCH = `1100011`
  - JALR = `1100111`
  - any other opcode is ILLEGAL.
- Immediate select by class:
  - IALU, LOAD, JALR → `I_TYPE`
  - STORE → `S_TYPE`
  - BRANCH → `B_TYPE`
  - R and ILLEGAL → default encoding (zero immediate).
  - `imm_type` is registered and held stable from EXECUTE until the next DECODE.
- IDLE: all outputs 0; go to FETCH unconditionally.
- FETCH: `imem_req`=1.
  - On `imem_ready`: `ir_we`=1 in that same cycle (Mealy), then go to DECODE.
- DECODE: latch class and `imm_type`.
  - ILLEGAL: pulse `illegal_instr`, `pc_we`=1 with `pc_src`=0, go to FETCH. The instruction is not retired.
  - Otherwise go to EXECUTE.
- EXECUTE: `alu_src_imm`=1 for all classes except R and BRANCH.
  - R, IALU, JALR → WRITEBACK.
  - LOAD, STORE → MEMORY.
  - BRANCH → `pc_we`=1, `pc_src` = `branch_taken` ? 1 : 0, retire, go to FETCH.
- MEMORY: `dmem_req`=1, `dmem_we` = (class==STORE), `alu_src_imm`=1.
  - On `dmem_ready`, LOAD → WRITEBACK.
  - On `dmem_ready`, STORE → `pc_we`=1, `pc_src`=0, retire, go to FETCH.
- WRITEBACK: `reg_we`=1 and `pc_we`=1, then retire and go to FETCH.
  - `wb_sel`: 1 for LOAD, 2 for JALR, 0 otherwise.
  - `pc_src`: 2 for JALR, 0 otherwise.
- Timeout:
  - A single down-counter is loaded with `MEM_TIMEOUT` on entry to FETCH or MEMORY and decrements each waiting cycle.
  - If it reaches 0 without ready: pulse `mem_fault`, drop the request, go to FETCH. The PC is not updated and nothing is retired; a data fault refetches the same PC.
  - If ready arrives in the same cycle the count reaches 0, ready wins.
- `retired` increments by exactly 1 per completed instruction and wraps modulo 2^`CNT_W`.

## Timing
- Reset (asynchronous, immediate): state = IDLE, `retired` = 0, `imm_type` = `I_TYPE`; every other output 0.
- The first `imem_req` appears one cycle after reset release.
- Cycle counts with zero-wait memory:
  - BRANCH 3 (FETCH, DECODE, EXECUTE)
  - R / IALU / JALR / STORE 4
  - LOAD 5
  - each memory wait cycle adds 1.
- `imem_req`/`dmem_req` stay high continuously until ready or timeout. The request deasserts in the cycle after ready is sampled.
- `pc_we`, `reg_we`, `ir_we`, `illegal_instr` and `mem_fault` are single-cycle pulses.
- Reset asserted mid-instruction aborts it: no writes occur and the retire count clears.

## Structure
- The `controls` package holds:
  - `Imm_ex_op` (existing)
  - new `seq_state_t` and `instr_class_t` enums
  - opcode localparams
  - `pc_src`/`wb_sel` encodings.
- One combinational sub-module, `opcode_classifier`, maps opcode → (`instr_class_t`, `Imm_ex_op`). The FSM, timeout counter and retire counter live in `instr_sequencer`.

## Test plan
- Reset held 3 cycles, then released, with `imem_ready`=1 → all outputs 0 during reset; `imem_req`=1 on the 2nd cycle after release.
- `opcode`=`0100011` (SW), zero-wait memory → `imm_type`=`S_TYPE` in EXECUTE; `dmem_req`=`dmem_we`=1; `pc_we` in cycle 4; `retired` 0→1.
- `opcode`=`1100011` with `branch_taken`=1, then again with 0 → `imm_type`=`B_TYPE`, `pc_src`=1 then 0, 3 cycles each, `reg_we` never asserted.
- LOAD with `dmem_ready` delayed 5 cycles → `dmem_req` high for 6 cycles; WRITEBACK has `wb_sel`=1 and `reg_we`=1; total 10 cycles.
- `MEM_TIMEOUT`=4 with `imem_ready` stuck at 0 → `mem_fault` pulse after 4 FETCH cycles; `pc_we`=0; `retired` unchanged; FETCH re-entered.
- `opcode`=`1111111` → `illegal_instr` pulse in DECODE, `pc_we` with `pc_src`=0, `retired` unchanged.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared control encodings for the multi-cycle RV32I sequencer: immediate select,
// FSM states, instruction classes, opcodes and datapath mux encodings.
package controls;

    typedef enum logic [1:0] {
        I_TYPE   = 2'd0,
        S_TYPE   = 2'd1,
        B_TYPE   = 2'd2,
        IMM_ZERO = 2'd3
    } Imm_ex_op;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5
    } seq_state_t;

    typedef enum logic [2:0] {
        CLS_R       = 3'd0,
        CLS_IALU    = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_JALR    = 3'd5,
        CLS_ILLEGAL = 3'd6
    } instr_class_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] PC_SRC_PC4    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JALR   = 2'd2;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_PC4  = 2'd2;

endpackage

// File: rtl/instr_sequencer_opcode_classifier.sv
// Combinational opcode decode into instruction class and sign-extender select.
module opcode_classifier
    import controls::*;
(
    input  logic [6:0]   opcode_i,
    output instr_class_t class_o,
    output Imm_ex_op     imm_type_o
);

    always_comb begin
        class_o    = CLS_ILLEGAL;
        imm_type_o = IMM_ZERO;
        case (opcode_i)
            OP_R:      class_o = CLS_R;
            OP_IALU:   begin class_o = CLS_IALU;   imm_type_o = I_TYPE; end
            OP_LOAD:   begin class_o = CLS_LOAD;   imm_type_o = I_TYPE; end
            OP_STORE:  begin class_o = CLS_STORE;  imm_type_o = S_TYPE; end
            OP_BRANCH: begin class_o = CLS_BRANCH; imm_type_o = B_TYPE; end
            OP_JALR:   begin class_o = CLS_JALR;   imm_type_o = I_TYPE; end
            default:   ;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer with a shared
// memory-wait timeout counter and a retired-instruction counter.
module instr_sequencer
    import controls::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [6:0]       opcode_i,
    input  logic             branch_taken_i,
    input  logic             imem_ready_i,
    input  logic             dmem_ready_i,
    output logic             imem_req_o,
    output logic             dmem_req_o,
    output logic             dmem_we_o,
    output logic             ir_we_o,
    output logic             pc_we_o,
    output logic [1:0]       pc_src_o,
    output Imm_ex_op         imm_type_o,
    output logic             alu_src_imm_o,
    output logic             reg_we_o,
    output logic [1:0]       wb_sel_o,
    output logic             illegal_instr_o,
    output logic             mem_fault_o,
    output logic [CNT_W-1:0] retired_o
);

    localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'(MEM_TIMEOUT);

    seq_state_t       state_q;
    instr_class_t     class_q;
    Imm_ex_op         imm_type_q;
    logic [TMR_W-1:0] timer_q;
    logic [CNT_W-1:0] retired_q;

    instr_class_t cls_dec;
    Imm_ex_op     imm_dec;
    logic         timed_out;
    logic         retire;

    opcode_classifier u_classifier (
        .opcode_i   (opcode_i),
        .class_o    (cls_dec),
        .imm_type_o (imm_dec)
    );

    // The last waiting cycle is the one where the count drops to zero; ready in that cycle still wins.
    assign timed_out = (timer_q == TMR_W'(1));

    always_comb begin
        imem_req_o      = 1'b0;
        dmem_req_o      = 1'b0;
        dmem_we_o       = 1'b0;
        ir_we_o         = 1'b0;
        pc_we_o         = 1'b0;
        pc_src_o        = PC_SRC_PC4;
        alu_src_imm_o   = 1'b0;
        reg_we_o        = 1'b0;
        wb_sel_o        = WB_SEL_ALU;
        illegal_instr_o = 1'b0;
        mem_fault_o     = 1'b0;
        retire          = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req_o  = 1'b1;
                ir_we_o     = imem_ready_i;
                mem_fault_o = !imem_ready_i && timed_out;
            end
            ST_DECODE: begin
                if (cls_dec == CLS_ILLEGAL) begin
                    illegal_instr_o = 1'b1;
                    pc_we_o         = 1'b1;
                end
            end
            ST_EXECUTE: begin
                alu_src_imm_o = !(class_q inside {CLS_R, CLS_BRANCH});
                if (class_q == CLS_BRANCH) begin
                    pc_we_o  = 1'b1;
                    pc_src_o = branch_taken_i ? PC_SRC_BRANCH : PC_SRC_PC4;
                    retire   = 1'b1;
                end
            end
            ST_MEMORY: begin
                dmem_req_o    = 1'b1;
                dmem_we_o     = (class_q == CLS_STORE);
                alu_src_imm_o = 1'b1;
                mem_fault_o   = !dmem_ready_i && timed_out;
                if (dmem_ready_i && class_q == CLS_STORE) begin
                    pc_we_o = 1'b1;
                    retire  = 1'b1;
                end
            end
            ST_WRITEBACK: begin
                reg_we_o = 1'b1;
                pc_we_o  = 1'b1;
                retire   = 1'b1;
                if (class_q == CLS_LOAD)      wb_sel_o = WB_SEL_LOAD;
                else if (class_q == CLS_JALR) wb_sel_o = WB_SEL_PC4;
                if (class_q == CLS_JALR)      pc_src_o = PC_SRC_JALR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            class_q    <= CLS_R;
            imm_type_q <= I_TYPE;
            timer_q    <= '0;
            retired_q  <= '0;
        end else begin
            if (retire) retired_q <= retired_q + CNT_W'(1);
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_FETCH;
                    timer_q <= TMO_LOAD;
                end
                ST_FETCH: begin
                    if (imem_ready_i)   state_q <= ST_DECODE;
                    else if (timed_out) timer_q <= TMO_LOAD;
                    else                timer_q <= timer_q - TMR_W'(1);
                end
                ST_DECODE: begin
                    class_q    <= cls_dec;
                    imm_type_q <= imm_dec;
                    if (cls_dec == CLS_ILLEGAL) begin
                        state_q <= ST_FETCH;
                        timer_q <= TMO_LOAD;
                    end else begin
                        state_q <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    if (class_q inside {CLS_LOAD, CLS_STORE}) begin
                        state_q <= ST_MEMORY;
                        timer_q <= TMO_LOAD;
                    end else if (class_q == CLS_BRANCH) begin
                        state_q <= ST_FETCH;
                        timer_q <= TMO_LOAD;
                    end else begin
                        state_q <= ST_WRITEBACK;
                    end
                end
                ST_MEMORY: begin
                    if (dmem_ready_i) begin
                        if (class_q == CLS_LOAD) begin
                            state_q <= ST_WRITEBACK;
                        end else begin
                            state_q <= ST_FETCH;
                            timer_q <= TMO_LOAD;
                        end
                    end else if (timed_out) begin
                        state_q <= ST_FETCH;
                        timer_q <= TMO_LOAD;
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                    end
                end
                ST_WRITEBACK: begin
                    state_q <= ST_FETCH;
                    timer_q <= TMO_LOAD;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign imm_type_o = imm_type_q;
    assign retired_o  = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench: per-cycle expected outputs are queued with their stimulus and
// compared as each cycle plays out; a second instance covers timeout and counter wrap.
module tb_instr_sequencer;
    import controls::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [6:0] opcode = 7'h0;
    logic branch_taken = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;

    logic imem_req, dmem_req, dmem_we, ir_we, pc_we, alu_src_imm, reg_we, illegal_instr, mem_fault;
    logic [1:0] pc_src, imm_type, wb_sel;
    logic [31:0] retired;

    logic t_imem_req, t_dmem_req, t_dmem_we, t_ir_we, t_pc_we, t_alu_src_imm, t_reg_we, t_illegal, t_fault;
    logic [1:0] t_pc_src, t_imm_type, t_wb_sel;
    logic [1:0] t_retired;

    always #5 clk = ~clk;

    instr_sequencer #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .branch_taken_i(branch_taken),
        .imem_ready_i(imem_ready), .dmem_ready_i(dmem_ready),
        .imem_req_o(imem_req), .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .ir_we_o(ir_we),
        .pc_we_o(pc_we), .pc_src_o(pc_src), .imm_type_o(imm_type), .alu_src_imm_o(alu_src_imm),
        .reg_we_o(reg_we), .wb_sel_o(wb_sel), .illegal_instr_o(illegal_instr),
        .mem_fault_o(mem_fault), .retired_o(retired)
    );

    instr_sequencer #(.MEM_TIMEOUT(4), .CNT_W(2)) dut_t4 (
        .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .branch_taken_i(branch_taken),
        .imem_ready_i(imem_ready), .dmem_ready_i(dmem_ready),
        .imem_req_o(t_imem_req), .dmem_req_o(t_dmem_req), .dmem_we_o(t_dmem_we), .ir_we_o(t_ir_we),
        .pc_we_o(t_pc_we), .pc_src_o(t_pc_src), .imm_type_o(t_imm_type), .alu_src_imm_o(t_alu_src_imm),
        .reg_we_o(t_reg_we), .wb_sel_o(t_wb_sel), .illegal_instr_o(t_illegal),
        .mem_fault_o(t_fault), .retired_o(t_retired)
    );

    typedef struct packed {
        logic       imem_req, dmem_req, dmem_we, ir_we, pc_we;
        logic [1:0] pc_src;
        logic [1:0] imm_type;
        logic       alu_src_imm, reg_we;
        logic [1:0] wb_sel;
        logic       illegal, fault;
    } outv_t;

    typedef struct {
        logic        ir, dr, bt;
        logic [6:0]  op;
        outv_t       o;
        int unsigned ret;
        bit          t4;
    } sb_t;

    outv_t got_m, got_t;
    assign got_m = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, imm_type,
                    alu_src_imm, reg_we, wb_sel, illegal_instr, mem_fault};
    assign got_t = {t_imem_req, t_dmem_req, t_dmem_we, t_ir_we, t_pc_we, t_pc_src, t_imm_type,
                    t_alu_src_imm, t_reg_we, t_wb_sel, t_illegal, t_fault};

    sb_t q[$];
    int checks = 0;
    int failures = 0;
    int unsigned exp_ret;
    logic [1:0] exp_imm;

    function automatic void push(input logic ir, input logic dr, input logic bt,
                                 input logic [6:0] op, input outv_t o, input bit t4);
        sb_t e;
        e.ir = ir; e.dr = dr; e.bt = bt; e.op = op; e.o = o; e.ret = exp_ret; e.t4 = t4;
        q.push_back(e);
    endfunction

    function automatic void push_idle(input bit t4);
        outv_t o;
        o = '0;
        o.imm_type = exp_imm;
        push(1'b0, 1'b0, 1'b0, 7'h0, o, t4);
    endfunction

    // Reference model of one instruction; iw/dw are wait cycles before ready, tmo the timeout.
    function automatic void push_instr(input logic [6:0] op, input logic bt, input int iw,
                                       input int dw, input int tmo, input bit t4);
        outv_t o;
        logic [1:0] imm_n;
        bit is_r, is_ld, is_st, is_br, is_jalr, legal;
        is_r = (op == 7'b0110011); is_ld = (op == 7'b0000011); is_st = (op == 7'b0100011);
        is_br = (op == 7'b1100011); is_jalr = (op == 7'b1100111);
        legal = is_r || is_ld || is_st || is_br || is_jalr || (op == 7'b0010011);
        imm_n = !legal || is_r ? IMM_ZERO : is_st ? S_TYPE : is_br ? B_TYPE : I_TYPE;
        for (int k = 0; k <= iw; k++) begin
            o = '0; o.imem_req = 1'b1; o.imm_type = exp_imm;
            if (k == iw) o.ir_we = 1'b1;
            else if (k == tmo - 1) begin
                o.fault = 1'b1;
                push(1'b0, 1'b0, bt, op, o, t4);
                return;
            end
            push(k == iw, 1'b0, bt, op, o, t4);
        end
        o = '0; o.imm_type = exp_imm;
        if (!legal) begin o.illegal = 1'b1; o.pc_we = 1'b1; end
        push(1'b0, 1'b0, bt, op, o, t4);
        exp_imm = imm_n;
        if (!legal) return;
        o = '0; o.imm_type = exp_imm; o.alu_src_imm = !(is_r || is_br);
        if (is_br) begin o.pc_we = 1'b1; o.pc_src = bt ? 2'd1 : 2'd0; end
        push(1'b0, 1'b0, bt, op, o, t4);
        if (is_br) begin exp_ret++; return; end
        if (is_ld || is_st) begin
            for (int k = 0; k <= dw; k++) begin
                o = '0; o.imm_type = exp_imm; o.dmem_req = 1'b1; o.dmem_we = is_st; o.alu_src_imm = 1'b1;
                if (k == dw) o.pc_we = is_st;
                else if (k == tmo - 1) begin
                    o.fault = 1'b1;
                    push(1'b0, 1'b0, bt, op, o, t4);
                    return;
                end
                push(1'b0, k == dw, bt, op, o, t4);
            end
            if (is_st) begin exp_ret++; return; end
        end
        o = '0; o.imm_type = exp_imm; o.reg_we = 1'b1; o.pc_we = 1'b1;
        o.wb_sel = is_ld ? 2'd1 : is_jalr ? 2'd2 : 2'd0;
        o.pc_src = is_jalr ? 2'd2 : 2'd0;
        push(1'b0, 1'b0, bt, op, o, t4);
        exp_ret++;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0; opcode = 7'h0;
        exp_imm = I_TYPE; exp_ret = 0; q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; imem_ready = 1'b1; opcode = OP_R;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++;
            if (got_m !== '0 || retired !== 32'd0) begin
                failures++;
                $display("FAIL reset_outputs got=%h ret=%0d exp=0 ret=0", got_m, retired);
            end
        end
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_first_cycle imem_req got=%b exp=0", imem_req); end
        @(negedge clk); #1;
        checks++;
        if (imem_req !== 1'b1 || ir_we !== 1'b1) begin
            failures++;
            $display("FAIL reset_second_cycle imem_req/ir_we got=%b%b exp=11", imem_req, ir_we);
        end
    endtask

    task automatic test_store_alu();
        sb_t e; outv_t g;
        do_reset();
        push_idle(0);
        push_instr(OP_STORE, 1'b0, 0, 0, 16, 0);
        push_instr(OP_IALU, 1'b0, 1, 0, 16, 0);
        push_instr(OP_JALR, 1'b0, 0, 0, 16, 0);
        push_instr(OP_R, 1'b0, 0, 0, 16, 0);
        while (q.size() != 0) begin
            e = q.pop_front();
            @(negedge clk);
            imem_ready = e.ir; dmem_ready = e.dr; branch_taken = e.bt; opcode = e.op;
            #1; g = got_m;
            checks++;
            if (g !== e.o) begin failures++; $display("FAIL store_alu outputs t=%0t got=%h exp=%h", $time, g, e.o); end
            checks++;
            if (retired !== e.ret) begin failures++; $display("FAIL store_alu retired t=%0t got=%0d exp=%0d", $time, retired, e.ret); end
        end
    endtask

    task automatic test_branch();
        sb_t e; outv_t g;
        do_reset();
        push_idle(0);
        push_instr(OP_BRANCH, 1'b1, 0, 0, 16, 0);
        push_instr(OP_BRANCH, 1'b0, 0, 0, 16, 0);
        while (q.size() != 0) begin
            e = q.pop_front();
            @(negedge clk);
            imem_ready = e.ir; dmem_ready = e.dr; branch_taken = e.bt; opcode = e.op;
            #1; g = got_m;
            checks++;
            if (g !== e.o) begin failures++; $display("FAIL branch outputs t=%0t got=%h exp=%h", $time, g, e.o); end
            checks++;
            if (retired !== e.ret) begin failures++; $display("FAIL branch retired t=%0t got=%0d exp=%0d", $time, retired, e.ret); end
        end
    endtask

    task automatic test_load_wait();
        sb_t e; outv_t g;
        do_reset();
        push_idle(0);
        push_instr(OP_LOAD, 1'b0, 0, 5, 16, 0);
        push_instr(OP_LOAD, 1'b0, 2, 0, 16, 0);
        while (q.size() != 0) begin
            e = q.pop_front();
            @(negedge clk);
            imem_ready = e.ir; dmem_ready = e.dr; branch_taken = e.bt; opcode = e.op;
            #1; g = got_m;
            checks++;
            if (g !== e.o) begin failures++; $display("FAIL load_wait outputs t=%0t got=%h exp=%h", $time, g, e.o); end
            checks++;
            if (retired !== e.ret) begin failures++; $display("FAIL load_wait retired t=%0t got=%0d exp=%0d", $time, retired, e.ret); end
        end
    endtask

    task automatic test_illegal();
        sb_t e; outv_t g;
        do_reset();
        push_idle(0);
        push_instr(7'b1111111, 1'b0, 0, 0, 16, 0);
        push_instr(OP_IALU, 1'b0, 0, 0, 16, 0);
        push_instr(7'b0000000, 1'b0, 0, 0, 16, 0);
        push_instr(OP_STORE, 1'b0, 0, 2, 16, 0);
        while (q.size() != 0) begin
            e = q.pop_front();
            @(negedge clk);
            imem_ready = e.ir; dmem_ready = e.dr; branch_taken = e.bt; opcode = e.op;
            #1; g = got_m;
            checks++;
            if (g !== e.o) begin failures++; $display("FAIL illegal outputs t=%0t got=%h exp=%h", $time, g, e.o); end
            checks++;
            if (retired !== e.ret) begin failures++; $display("FAIL illegal retired t=%0t got=%0d exp=%0d", $time, retired, e.ret); end
        end
    endtask

    task automatic test_timeout_wrap();
        sb_t e; outv_t g;
        do_reset();
        push_idle(1);
        push_instr(OP_BRANCH, 1'b1, 100, 0, 4, 1);
        push_instr(OP_BRANCH, 1'b1, 100, 0, 4, 1);
        push_instr(OP_BRANCH, 1'b1, 3, 0, 4, 1);
        for (int i = 0; i < 4; i++) push_instr(OP_BRANCH, 1'(i), 0, 0, 4, 1);
        push_instr(OP_LOAD, 1'b0, 0, 100, 4, 1);
        push_instr(OP_LOAD, 1'b0, 0, 3, 4, 1);
        while (q.size() != 0) begin
            e = q.pop_front();
            @(negedge clk);
            imem_ready = e.ir; dmem_ready = e.dr; branch_taken = e.bt; opcode = e.op;
            #1; g = got_t;
            checks++;
            if (g !== e.o) begin failures++; $display("FAIL timeout outputs t=%0t got=%h exp=%h", $time, g, e.o); end
            checks++;
            if (32'(t_retired) !== (e.ret & 32'd3)) begin
                failures++;
                $display("FAIL timeout retired t=%0t got=%0d exp=%0d", $time, t_retired, e.ret & 32'd3);
            end
        end
    endtask

    task automatic test_reset_mid();
        sb_t e; outv_t g;
        do_reset();
        push_idle(0);
        push_instr(OP_R, 1'b0, 0, 0, 16, 0);
        push_instr(OP_LOAD, 1'b0, 0, 3, 16, 0);
        while (q.size() > 2) begin
            e = q.pop_front();
            @(negedge clk);
            imem_ready = e.ir; dmem_ready = e.dr; branch_taken = e.bt; opcode = e.op;
            #1; g = got_m;
            checks++;
            if (g !== e.o) begin failures++; $display("FAIL reset_mid outputs t=%0t got=%h exp=%h", $time, g, e.o); end
            checks++;
            if (retired !== e.ret) begin failures++; $display("FAIL reset_mid retired t=%0t got=%0d exp=%0d", $time, retired, e.ret); end
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (got_m !== '0 || retired !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_abort got=%h ret=%0d exp=0 ret=0", got_m, retired);
        end
        q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_alu();
        test_branch();
        test_load_wait();
        test_illegal();
        test_timeout_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
